// File: rtl/bcd_pkg.sv
// bcd_pkg: shared definitions for the digit-serial BCD adder/subtractor.
//   - state encoding for the sequencer FSM
//   - BCD digit width and the constant nine used for nine's complement
//   - digit_ok(): true when a 4-bit digit is a legal BCD digit (0..9)
package bcd_pkg;

  localparam int          BCD_W    = 4;
  localparam logic [3:0]  BCD_NINE = 4'd9;

  typedef logic [1:0] state_t;
  localparam state_t ST_IDLE   = 2'd0;
  localparam state_t ST_ADD    = 2'd1;
  localparam state_t ST_NEGATE = 2'd2;
  localparam state_t ST_DONE   = 2'd3;

  function automatic logic digit_ok(input logic [BCD_W-1:0] d);
    return d <= BCD_NINE;
  endfunction

endpackage

// File: rtl/bcd_digit_add.sv
// bcd_digit_add: combinational single-digit BCD adder.
//   a, b : BCD digits (0..9)
//   ci   : decimal carry in
//   s    : BCD sum digit
//   co   : decimal carry out
module bcd_digit_add
  import bcd_pkg::*;
(
  input  logic [BCD_W-1:0] a,
  input  logic [BCD_W-1:0] b,
  input  logic             ci,
  output logic [BCD_W-1:0] s,
  output logic             co
);

  logic [BCD_W:0] bin_sum;
  logic [BCD_W:0] adj_sum;

  always_comb begin
    bin_sum = {1'b0, a} + {1'b0, b} + {{BCD_W{1'b0}}, ci};
    // Anything past 9 (including a binary carry) wraps by adding 6,
    // which skips the six unused codes A..F.
    co      = (bin_sum > 5'd9);
    adj_sum = co ? (bin_sum + 5'd6) : bin_sum;
    s       = adj_sum[BCD_W-1:0];
  end

endmodule

// File: rtl/bcd_seq_adder.sv
// bcd_seq_adder: digit-serial multi-digit BCD adder/subtractor.
//   clk, reset : clock, synchronous active-high reset
//   start      : request, accepted only in IDLE
//   sub        : 0 = a+b+cin, 1 = a-b (signed magnitude result)
//   cin        : decimal carry in (add only)
//   a, b       : packed BCD operands, digit 0 in bits [3:0]
//   busy       : high in every state but IDLE
//   done       : one-cycle completion pulse
//   s          : BCD result (magnitude when neg=1)
//   cout       : decimal carry out (add only)
//   neg        : subtract result negative
//   err        : an operand digit was > 9
module bcd_seq_adder
  import bcd_pkg::*;
#(
  parameter int DIGITS = 4
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  start,
  input  logic                  sub,
  input  logic                  cin,
  input  logic [4*DIGITS-1:0]   a,
  input  logic [4*DIGITS-1:0]   b,
  output logic                  busy,
  output logic                  done,
  output logic [4*DIGITS-1:0]   s,
  output logic                  cout,
  output logic                  neg,
  output logic                  err
);

  localparam int IDX_W = (DIGITS > 1) ? $clog2(DIGITS) : 1;
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(DIGITS - 1);

  typedef logic [DIGITS-1:0][BCD_W-1:0] dig_vec_t;

  state_t           state_q, state_d;
  dig_vec_t         a_q, a_d, b_q, b_d, s_q, s_d;
  logic [IDX_W-1:0] idx_q, idx_d;
  logic             sub_q, sub_d;
  logic             carry_q, carry_d;
  logic             cout_q, cout_d;
  logic             neg_q, neg_d;
  logic             err_q, err_d;

  dig_vec_t         a_in, b_in;
  logic             in_bad;
  logic [BCD_W-1:0] cell_a, cell_b, cell_s;
  logic             cell_co;
  logic             last_dig;

  assign a_in     = a;
  assign b_in     = b;
  assign last_dig = (idx_q == LAST_IDX);

  always_comb begin
    in_bad = 1'b0;
    for (int i = 0; i < DIGITS; i++)
      if (!digit_ok(a_in[i]) || !digit_ok(b_in[i])) in_bad = 1'b1;
  end

  // One adder cell shared by both passes. ADD uses a + (b or 9-b);
  // NEGATE rewrites the result in place as its ten's complement.
  always_comb begin
    cell_a = a_q[idx_q];
    cell_b = sub_q ? (BCD_NINE - b_q[idx_q]) : b_q[idx_q];
    if (state_q == ST_NEGATE) begin
      cell_a = BCD_NINE - s_q[idx_q];
      cell_b = '0;
    end
  end

  bcd_digit_add u_cell (
    .a  (cell_a),
    .b  (cell_b),
    .ci (carry_q),
    .s  (cell_s),
    .co (cell_co)
  );

  // Next-state logic
  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE:   if (start) state_d = in_bad ? ST_DONE : ST_ADD;
      // In subtract, no final carry means a < b: result needs negation.
      ST_ADD:    if (last_dig) state_d = (sub_q && !cell_co) ? ST_NEGATE : ST_DONE;
      ST_NEGATE: if (last_dig) state_d = ST_DONE;
      default:   state_d = ST_IDLE;
    endcase
  end

  // Datapath next values
  always_comb begin
    a_d     = a_q;
    b_d     = b_q;
    s_d     = s_q;
    idx_d   = idx_q;
    sub_d   = sub_q;
    carry_d = carry_q;
    cout_d  = cout_q;
    neg_d   = neg_q;
    err_d   = err_q;
    case (state_q)
      ST_IDLE: if (start) begin
        a_d     = a_in;
        b_d     = b_in;
        sub_d   = sub;
        carry_d = sub ? 1'b1 : cin;  // +1 turns nine's complement into ten's
        s_d     = '0;
        idx_d   = '0;
        cout_d  = 1'b0;
        neg_d   = 1'b0;
        err_d   = in_bad;
      end
      ST_ADD: begin
        s_d[idx_q] = cell_s;
        carry_d    = cell_co;
        idx_d      = idx_q + 1'b1;
        if (last_dig) begin
          idx_d = '0;
          if (!sub_q)        cout_d  = cell_co;
          else if (!cell_co) carry_d = 1'b1;
        end
      end
      ST_NEGATE: begin
        s_d[idx_q] = cell_s;
        carry_d    = cell_co;
        idx_d      = idx_q + 1'b1;
        if (last_dig) begin
          idx_d = '0;
          neg_d = 1'b1;
        end
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= ST_IDLE;
      a_q     <= '0;
      b_q     <= '0;
      s_q     <= '0;
      idx_q   <= '0;
      sub_q   <= 1'b0;
      carry_q <= 1'b0;
      cout_q  <= 1'b0;
      neg_q   <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      a_q     <= a_d;
      b_q     <= b_d;
      s_q     <= s_d;
      idx_q   <= idx_d;
      sub_q   <= sub_d;
      carry_q <= carry_d;
      cout_q  <= cout_d;
      neg_q   <= neg_d;
      err_q   <= err_d;
    end
  end

  // Outputs: all decoded from flops only
  always_comb begin
    busy = (state_q != ST_IDLE);
    done = (state_q == ST_DONE);
    s    = s_q;
    cout = cout_q;
    neg  = neg_q;
    err  = err_q;
  end

endmodule

// File: tb/tb_bcd_seq_adder.sv
// tb_bcd_seq_adder: directed + randomized check of bcd_seq_adder (DIGITS=4)
// against a decimal-arithmetic reference model.
module tb_bcd_seq_adder;

  localparam int D = 4;
  localparam int W = 4 * D;

  logic         clk, reset, start, sub, cin;
  logic [W-1:0] a, b, s;
  logic         busy, done, cout, neg, err;

  int n_tests = 0;
  int n_fail  = 0;

  bcd_seq_adder #(.DIGITS(D)) dut (
    .clk   (clk),
    .reset (reset),
    .start (start),
    .sub   (sub),
    .cin   (cin),
    .a     (a),
    .b     (b),
    .busy  (busy),
    .done  (done),
    .s     (s),
    .cout  (cout),
    .neg   (neg),
    .err   (err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic int bcd2int(input logic [W-1:0] v);
    int r = 0;
    for (int i = D - 1; i >= 0; i--) r = r * 10 + int'(v[4*i +: 4]);
    return r;
  endfunction

  function automatic logic [W-1:0] int2bcd(input int v);
    logic [W-1:0] r = '0;
    for (int i = 0; i < D; i++) begin
      r[4*i +: 4] = 4'(v % 10);
      v = v / 10;
    end
    return r;
  endfunction

  function automatic logic is_valid(input logic [W-1:0] v);
    for (int i = 0; i < D; i++) if (v[4*i +: 4] > 4'd9) return 1'b0;
    return 1'b1;
  endfunction

  // Runs one operation from IDLE; optionally pulses start at cycle glitch_cyc.
  task automatic run_op(input logic sub_i, input logic cin_i,
                        input logic [W-1:0] a_i, input logic [W-1:0] b_i,
                        input int glitch_cyc);
    int           va, vb, r, lat, cyc;
    logic [W-1:0] exp_s;
    logic         exp_cout, exp_neg, exp_err;
    int           modv = 10 ** D;

    va = bcd2int(a_i);
    vb = bcd2int(b_i);
    exp_err = !(is_valid(a_i) && is_valid(b_i));
    exp_cout = 1'b0;
    exp_neg  = 1'b0;
    exp_s    = '0;
    if (exp_err) begin
      lat = 1;
    end else if (!sub_i) begin
      r = va + vb + int'(cin_i);
      exp_cout = (r >= modv);
      exp_s    = int2bcd(r % modv);
      lat      = D + 1;
    end else begin
      r = va - vb;
      exp_neg = (r < 0);
      exp_s   = int2bcd(r < 0 ? -r : r);
      lat     = exp_neg ? 2 * D + 1 : D + 1;
    end

    start = 1'b1; sub = sub_i; cin = cin_i; a = a_i; b = b_i;
    @(posedge clk); #1;
    start = 1'b0;
    a = W'($urandom); b = W'($urandom); sub = 1'($urandom); cin = 1'($urandom);
    cyc = 1;
    chk("busy_c1", busy, 1);
    while (!done && cyc < 60) begin
      if (cyc == glitch_cyc) start = 1'b1;
      @(posedge clk); #1;
      start = 1'b0;
      cyc++;
    end
    chk("done_seen", done, 1);
    chk("latency", cyc, lat);
    chk("busy_done", busy, 1);
    chk("s", s, exp_s);
    chk("cout", cout, exp_cout);
    chk("neg", neg, exp_neg);
    chk("err", err, exp_err);
    // start during DONE must not be accepted
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    chk("done_pulse", done, 0);
    chk("idle_busy", busy, 0);
    chk("s_hold", s, exp_s);
    chk("neg_hold", neg, exp_neg);
  endtask

  initial begin
    logic [W-1:0] ra, rb;
    reset = 1'b1; start = 1'b0; sub = 1'b0; cin = 1'b0; a = '0; b = '0;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
    chk("rst_s", s, 0);
    chk("rst_cout", cout, 0);
    chk("rst_neg", neg, 0);
    chk("rst_err", err, 0);
    reset = 1'b0;
    @(posedge clk); #1;

    run_op(1'b0, 1'b0, 16'h1234, 16'h8766, 0);
    run_op(1'b0, 1'b1, 16'h9999, 16'h0000, 0);
    run_op(1'b0, 1'b0, 16'h9999, 16'h0000, 0);
    run_op(1'b1, 1'b1, 16'h5000, 16'h1234, 0);
    run_op(1'b1, 1'b0, 16'h0420, 16'h0420, 0);
    run_op(1'b1, 1'b0, 16'h1234, 16'h5000, 3);
    run_op(1'b0, 1'b0, 16'h12A4, 16'h0000, 0);
    run_op(1'b1, 1'b0, 16'h0000, 16'h9999, 0);

    for (int k = 0; k < 150; k++) begin
      ra = int2bcd(int'($urandom_range(0, 9999)));
      rb = int2bcd(int'($urandom_range(0, 9999)));
      if ($urandom_range(0, 9) == 0) ra[4*$urandom_range(0, D-1) +: 4] = 4'($urandom_range(10, 15));
      if ($urandom_range(0, 9) == 0) rb[4*$urandom_range(0, D-1) +: 4] = 4'($urandom_range(10, 15));
      run_op(1'($urandom), 1'($urandom), ra, rb, (k % 5 == 0) ? int'($urandom_range(2, 8)) : 0);
    end

    // reset in the middle of an add
    run_op(1'b0, 1'b0, 16'h4321, 16'h1111, 0);
    start = 1'b1; sub = 1'b0; cin = 1'b0; a = 16'h5555; b = 16'h5555;
    @(posedge clk); #1;
    start = 1'b0;
    @(posedge clk); #1;
    @(posedge clk); #1;
    reset = 1'b1;
    @(posedge clk); #1;
    reset = 1'b0;
    chk("mid_rst_busy", busy, 0);
    chk("mid_rst_done", done, 0);
    chk("mid_rst_s", s, 0);
    chk("mid_rst_cout", cout, 0);
    chk("mid_rst_neg", neg, 0);
    chk("mid_rst_err", err, 0);
    for (int k = 0; k < 8; k++) begin
      @(posedge clk); #1;
      chk("mid_rst_no_done", done, 0);
    end
    run_op(1'b0, 1'b1, 16'h5555, 16'h5555, 0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
